// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the master's state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator with a stall watchdog.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | awvalid/wvalid up; each drops after its own handshake
// WR_RESP | bready high, waiting for bvalid
// RD_REQ  | arvalid up until arready
// RD_DATA | rready high, waiting for rvalid
// RSP     | rsp_valid high with stable fields until rsp_ready
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WDOG_MAX = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic              write_q, write_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [CNT_W-1:0]  wdog_q, wdog_d;
    logic              timeout_q, timeout_d;

    logic cmd_accept;
    logic aw_hs;
    logic w_hs;
    logic bus_wait;

    // cmd_ready is also gated by reset so it reads 0 while reset is held.
    assign cmd_ready  = (state_q == IDLE) && reset_n;
    assign cmd_accept = cmd_valid && cmd_ready;

    assign awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign bready  = (state_q == WR_RESP);
    assign arvalid = (state_q == RD_REQ);
    assign rready  = (state_q == RD_DATA);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    assign bus_wait = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                      (state_q == RD_REQ) || (state_q == RD_DATA);

    assign rsp_valid   = (state_q == RSP);
    assign rsp_write   = write_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign timeout_err = timeout_q;
    assign awaddr      = awaddr_q;
    assign wdata       = wdata_q;
    assign araddr      = araddr_q;

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_accept) state_d = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
            WR_RESP: if (bvalid) state_d = RSP;
            RD_REQ:  if (arready) state_d = RD_DATA;
            RD_DATA: if (rvalid) state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command capture, per-channel handshake tracking and response capture
    always_comb begin
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        write_d   = write_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        if (cmd_accept) begin
            write_d   = cmd_write;
            rdata_d   = '0;
            resp_d    = RESP_OKAY;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (cmd_write) begin
                awaddr_d = cmd_addr;
                wdata_d  = cmd_wdata;
            end else begin
                araddr_d = cmd_addr;
            end
        end
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((state_q == WR_RESP) && bvalid) resp_d = bresp;
        if ((state_q == RD_DATA) && rvalid) begin
            rdata_d = rdata;
            resp_d  = rresp;
        end
    end

    // Watchdog: restarts on every state change, saturates, never aborts the transfer
    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (bus_wait && (wdog_q != WDOG_MAX)) begin
            wdog_d = wdog_q + CNT_W'(1);
        end
        if (cmd_accept) begin
            timeout_d = 1'b0;
        end else if (bus_wait && (wdog_d == WDOG_MAX)) begin
            timeout_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            write_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            write_q   <= write_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: randomized AXI-Lite slave model, reference memory
// model feeding a response scoreboard, and directed timing/watchdog/reset cases.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout_err;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic          wr;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [AW-1:0] cur_wr_addr = '0, cur_rd_addr = '0;
    logic [DW-1:0] cur_wdata = '0;

    // The slave environment answers with a response code chosen by address bits [5:4]
    // and returns ~addr for locations never written.
    function automatic logic [1:0] resp_for(input logic [AW-1:0] a);
        return a[5:4];
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return ~a;
    endfunction

    // ---------------- slave model ----------------
    int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit            aw_hold = 0;
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit            aw_got, w_got, b_pend, r_pend;
    bit            hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic [AW-1:0] s_waddr, s_araddr;
    logic [DW-1:0] s_wdata;
    logic [1:0]    s_bresp;
    logic [DW-1:0] slv_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] slv_read(input logic [AW-1:0] a);
        if (slv_mem.exists(a)) return slv_mem[a];
        return ~a;
    endfunction

    task slave_clear();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    endtask

    initial begin
        slave_clear();
        s_waddr = '0; s_araddr = '0; s_wdata = '0; s_bresp = '0;
        forever begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_b  = bvalid && bready;
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            // the write address is taken at the W handshake, relying on awaddr holding
            if (hs_w) begin s_waddr = awaddr; s_wdata = wdata; end
            if (hs_ar) s_araddr = araddr;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                slave_clear();
            end else begin
                if (hs_aw) begin aw_got = 1; aw_cnt = 0; end
                if (hs_w)  begin w_got = 1;  w_cnt = 0;  end
                if (aw_got && w_got) begin
                    slv_mem[s_waddr] = s_wdata;
                    s_bresp = resp_for(s_waddr);
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                end
                if (hs_b) b_pend = 0;
                if (hs_ar) begin r_pend = 1; r_cnt = 0; ar_cnt = 0; end
                if (hs_r) r_pend = 0;

                awready = awvalid && !aw_hold && (aw_cnt >= aw_dly);
                if (awvalid) aw_cnt++;
                wready = wvalid && (w_cnt >= w_dly);
                if (wvalid) w_cnt++;
                bvalid = b_pend && (b_cnt >= b_dly);
                bresp  = bvalid ? s_bresp : 2'b00;
                if (b_pend) b_cnt++;
                arready = arvalid && (ar_cnt >= ar_dly);
                if (arvalid) ar_cnt++;
                rvalid = r_pend && (r_cnt >= r_dly);
                rdata  = rvalid ? slv_read(s_araddr) : '0;
                rresp  = rvalid ? resp_for(s_araddr) : 2'b00;
                if (r_pend) r_cnt++;
            end
        end
    end

    // ---------------- response back-pressure ----------------
    bit rsp_hold = 0, rsp_bp = 0;
    initial begin
        rsp_ready = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rsp_hold)    rsp_ready = 0;
            else if (rsp_bp) rsp_ready = ($urandom_range(0, 3) != 0);
            else             rsp_ready = 1;
        end
    end

    // ---------------- monitor: scoreboard + protocol stability ----------------
    bit            rst_flag = 1;
    int            rsp_cnt = 0, b_hs_cnt = 0, rready_wait_cnt = 0;
    logic          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr, p_rw;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata, p_rd;
    logic [1:0]    p_rs;

    initial begin
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        p_rv = 0; p_rr = 0; p_rw = 0; p_awaddr = 0; p_araddr = 0; p_wdata = 0;
        p_rd = 0; p_rs = 0;
        forever begin
            @(negedge clk);
            if (!reset_n || rst_flag) begin
                if (reset_n) rst_flag = 0;
                p_awv = 0; p_wv = 0; p_arv = 0; p_rv = 0; p_rr = 0;
            end else begin
                if (p_awv && !p_awr) chk("awvalid_hold", 64'({awvalid, awaddr}), 64'({1'b1, p_awaddr}));
                if (p_wv && !p_wr)   chk("wvalid_hold", 64'({wvalid, wdata}), 64'({1'b1, p_wdata}));
                if (p_arv && !p_arr) chk("arvalid_hold", 64'({arvalid, araddr}), 64'({1'b1, p_araddr}));
                if (p_rv && !p_rr)
                    chk("rsp_hold", 64'({rsp_valid, rsp_write, rsp_rdata, rsp_resp, cmd_ready}),
                        64'({1'b1, p_rw, p_rd, p_rs, 1'b0}));
                if (p_rv && p_rr) chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'(1));
                if (awvalid || wvalid)
                    chk("aw_addr_data", 64'({awaddr, wdata}), 64'({cur_wr_addr, cur_wdata}));
                if (arvalid) chk("ar_addr", 64'(araddr), 64'(cur_rd_addr));
                if (bvalid && bready) b_hs_cnt++;
                if (rready && !rvalid) rready_wait_cnt++;
                if (rsp_valid && rsp_ready) begin
                    rsp_cnt++;
                    if (sb_q.size() == 0) begin
                        chk("rsp_unexpected", 64'(sb_q.size()), 64'(1));
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("rsp_write", 64'(rsp_write), 64'(e.wr));
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                    end
                end
                p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
                p_wv = wvalid; p_wr = wready; p_wdata = wdata;
                p_arv = arvalid; p_arr = arready; p_araddr = araddr;
                p_rv = rsp_valid; p_rr = rsp_ready; p_rw = rsp_write; p_rd = rsp_rdata; p_rs = rsp_resp;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that follows acceptance.
    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         output int waited);
        exp_t e;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_valid = 1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            waited++;
            if (waited > 200) break;
        end
        if (!cmd_ready) begin
            fail("cmd_accept", "cmd_ready never rose");
        end else begin
            e.wr = wr;
            e.resp = resp_for(addr);
            if (wr) begin
                ref_mem[addr] = data;
                e.rdata = '0;
                cur_wr_addr = addr;
                cur_wdata = data;
            end else begin
                e.rdata = ref_read(addr);
                cur_rd_addr = addr;
            end
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (rsp_valid || n > 300) break;
        end
        if (!rsp_valid) fail("rsp_wait", "rsp_valid never rose");
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) fail("rsp_drain", "expected response never arrived");
    endtask

    task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n, w0, b0, r0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                                  timeout_err, awaddr, wdata}), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1;
        @(negedge clk);
        chk("reset_release_cmd_ready", 64'(cmd_ready), 64'(1));
        tick();

        // zero-wait slave latency: write then read
        set_dly(0, 0, 0, 0, 0);
        issue(1, 32'h4, 32'h1234_5678, n);
        wait_rsp(n);
        chk("wr_latency_zero_wait", 64'(n), 64'(3));
        wait_idle();
        issue(0, 32'h4, '0, n);
        wait_rsp(n);
        chk("rd_latency_zero_wait", 64'(n), 64'(3));
        wait_idle();

        // slave ready one cycle after valid; write 0x8 then read it back
        set_dly(1, 1, 0, 1, 0);
        issue(1, 32'h8, 32'hDEAD_BEEF, n);
        wait_rsp(n);
        chk("wr_latency_one_wait", 64'(n), 64'(4));
        wait_idle();
        issue(0, 32'h8, '0, n);
        wait_idle();

        // wready three cycles before awready
        set_dly(3, 0, 1, 0, 0);
        b0 = b_hs_cnt; r0 = rsp_cnt;
        issue(1, 32'h10, 32'hA5A5_0F0F, n);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("w_drop_aw_hold", 64'({wvalid, awvalid}), 64'(2'b01));
        tick();
        wait_idle();
        repeat (3) tick();
        chk("single_b_handshake", 64'(b_hs_cnt - b0), 64'(1));
        chk("single_rsp", 64'(rsp_cnt - r0), 64'(1));

        // read with rvalid delayed five cycles, SLVERR from the address map
        set_dly(0, 0, 0, 0, 5);
        w0 = rready_wait_cnt;
        issue(0, 32'h20, '0, n);
        wait_idle();
        chk("rready_wait_cycles", 64'(rready_wait_cnt - w0), 64'(5));

        // response held off for ten cycles, then next command right behind it
        set_dly(0, 0, 0, 0, 0);
        rsp_hold = 1;
        issue(1, 32'h30, 32'hCAFE_F00D, n);
        wait_rsp(n);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("rsp_stall_cmd_ready", 64'({cmd_ready, rsp_valid}), 64'(2'b01));
            tick();
        end
        rsp_hold = 0;
        issue(0, 32'h30, '0, n);
        chk("accept_after_rsp", 64'(n), 64'(1));
        wait_idle();

        // watchdog: awready withheld
        aw_hold = 1;
        issue(1, 32'h14, 32'h0BAD_CAFE, n);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 8) chk("timeout_before_limit", 64'(timeout_err), 64'(0));
            if (k == 9) chk("timeout_set", 64'({timeout_err, awvalid}), 64'(2'b11));
            tick();
        end
        repeat (5) tick();
        chk("timeout_saturated_wait", 64'({timeout_err, awvalid}), 64'(2'b11));
        aw_hold = 0;
        wait_idle();
        chk("timeout_sticky", 64'(timeout_err), 64'(1));
        issue(0, 32'h14, '0, n);
        @(negedge clk);
        chk("timeout_clear_on_accept", 64'(timeout_err), 64'(0));
        tick();
        wait_idle();

        // reset during RD_DATA
        set_dly(0, 0, 0, 0, 30);
        issue(0, 32'h8, '0, n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (rready || n > 50) break;
        end
        if (!rready) fail("reach_rd_data", "rready never rose");
        #2;
        rst_flag = 1;
        reset_n = 0;
        #1;
        chk("reset_async_drop", 64'({arvalid, rready, rsp_valid, cmd_ready}), 64'(0));
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1;
        @(negedge clk);
        chk("reset_mid_cmd_ready", 64'(cmd_ready), 64'(1));
        tick();
        set_dly(0, 0, 0, 0, 0);
        repeat (3) tick();
        issue(0, 32'h8, '0, n);
        wait_idle();

        // randomized traffic with back-pressure
        rsp_bp = 1;
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 15) * 4);
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            issue($urandom_range(0, 1) == 1, a, $urandom, n);
            wait_idle();
        end
        rsp_bp = 0;
        repeat (5) tick();
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
